byte_pack_in: RTL



---
 rtl/byte_pack_in_pkg.sv | 13 +
 rtl/byte_pack_in.sv | 103 ++++++++++
 2 files changed

// File: rtl/byte_pack_in_pkg.sv
// Shared definitions for the byte packer: state encoding, byte width and the
// default word length also used by the matching serializer.
package byte_pack_in_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_BYTES = 5;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } pack_state_t;

endpackage

// File: rtl/byte_pack_in.sv
// Byte-to-word packer: assembles BYTES bytes into one word with valid/ack output.
// Optional idle timeout that drops a stale partial word: BYTE_PACK_TIMEOUT_EN.
module byte_pack_in
  import byte_pack_in_pkg::*;
#(
  parameter int MSB_FIRST = 1,
  parameter int BYTES     = DEF_BYTES,
  parameter int TIMEOUT   = 16
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     din,
  input  logic                  din_valid,
  input  logic                  din_sof,
  output logic                  din_ready,
  output logic [BYTE_W*BYTES-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ack,
  output logic                  drop_err
);

  localparam int W  = BYTE_W * BYTES;
  localparam int CW = $clog2(BYTES + 1);

  pack_state_t   state, next_state;
  logic [CW-1:0] cnt, cnt_base;
  logic [W-1:0]  asm_q, asm_d;
  logic          accept, sof_drop, last, timeout;

  assign accept   = din_valid && din_ready;
  assign sof_drop = accept && din_sof && (cnt != '0);
  assign cnt_base = din_sof ? '0 : cnt;
  assign last     = accept && (cnt_base == CW'(BYTES - 1));

  // A full shift of BYTES bytes flushes any discarded partial word, so the
  // assembly buffer never needs clearing on sof.
  always_comb begin
    asm_d = asm_q;
    if (MSB_FIRST != 0)
      asm_d = (asm_q << BYTE_W) | W'(din);
    else
      asm_d = (asm_q >> BYTE_W) | (W'(din) << (W - BYTE_W));
  end

`ifdef BYTE_PACK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;

  assign timeout = (state == COLLECT) && (cnt != '0) && !accept &&
                   (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      idle_q <= '0;
    else if (accept || state != COLLECT || cnt == '0 || timeout)
      idle_q <= '0;
    else
      idle_q <= idle_q + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge rst) begin
    if (rst)
      state <= COLLECT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (last)
      next_state = FULL;
    else if (state == FULL && dout_ack)
      next_state = COLLECT;
  end

  always_comb begin
    din_ready  = (state == COLLECT) || dout_ack;
    dout_valid = (state == FULL);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      asm_q    <= '0;
      dout     <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= sof_drop || timeout;
      if (accept) begin
        asm_q <= asm_d;
        cnt   <= last ? '0 : cnt_base + CW'(1);
        if (last)
          dout <= asm_d;
      end else if (timeout) begin
        cnt <= '0;
      end
    end
  end

endmodule
